// File: rtl/uart_word_sender_if.sv
// Word handshake between the core/dump logic and the UART word sender.
//   word_data  : 32-bit word to transmit
//   word_valid : word_data valid; transfer when word_valid && word_ready
//   word_ready : sender accepts a word this cycle
//   finish     : one-cycle request to append the end marker
interface uart_word_sender_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        finish;

  modport master (output word_data, output word_valid, output finish, input word_ready);
  modport slave  (input word_data, input word_valid, input finish, output word_ready);
endinterface

// File: rtl/uart_word_sender.sv
// Sends queued 32-bit words over UART 8N1, MSB byte first, and appends the
// 0xFFFFFFFF end marker on a finish request.
//   CLK     : system clock
//   RST_N   : asynchronous active-low reset
//   wbus    : word handshake (slave side), see uart_word_sender_if
//   UART_TX : serial line, idle high
//   busy    : words queued, frame in progress, or end marker pending/active
//   done    : end marker fully sent; sticky until reset
module uart_word_sender #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  uart_word_sender_if.slave   wbus,
  output logic                UART_TX,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        shift_word;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic               fin_pending;
  logic               term_active;

  logic               push;
  logic               pop;
  logic               baud_last;
  logic [7:0]         cur_byte;

  assign wbus.word_ready = (count < CNT_W'(FIFO_DEPTH)) && !fin_pending && !done;
  assign push            = wbus.word_valid && wbus.word_ready;
  assign pop             = (state == IDLE) && (count != '0) && !done;
  assign baud_last       = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy            = (count != '0) || (state != IDLE) || fin_pending || term_active;

  // Byte selection, MSB byte first.
  always_comb begin
    cur_byte = shift_word[31:24];
    case (byte_idx)
      2'd0: cur_byte = shift_word[31:24];
      2'd1: cur_byte = shift_word[23:16];
      2'd2: cur_byte = shift_word[15:8];
      2'd3: cur_byte = shift_word[7:0];
      default: cur_byte = shift_word[31:24];
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wbus.word_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Framing FSM. UART_TX reflects the state of the previous cycle, so the
  // line goes low one cycle after the pop that starts a word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      shift_word  <= '0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      fin_pending <= 1'b0;
      term_active <= 1'b0;
      done        <= 1'b0;
      UART_TX     <= 1'b1;
    end else begin
      if (wbus.finish && !fin_pending && !done) fin_pending <= 1'b1;

      case (state)
        IDLE:  UART_TX <= 1'b1;
        START: UART_TX <= 1'b0;
        DATA:  UART_TX <= cur_byte[bit_idx];
        STOP:  UART_TX <= 1'b1;
        default: UART_TX <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          // Queued words always go out before the end marker.
          if (pop) begin
            shift_word <= mem[rd_ptr];
            byte_idx   <= '0;
            state      <= START;
          end else if (fin_pending && !done) begin
            shift_word  <= 32'hFFFF_FFFF;
            byte_idx    <= '0;
            fin_pending <= 1'b0;
            term_active <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
            end else begin
              state <= IDLE;
              if (term_active) begin
                done        <= 1'b1;
                term_active <= 1'b0;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench for uart_word_sender with a bit-accurate 8N1 line monitor.
module tb_uart_word_sender;

  localparam int unsigned CPB = 4;

  logic CLK;
  logic RST_N;
  logic UART_TX;
  logic busy;
  logic done;

  uart_word_sender_if bus();

  uart_word_sender #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wbus    (bus),
    .UART_TX (UART_TX),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_miss;

  // 8N1 monitor: samples mid-bit on falling edges.
  logic [7:0] rxq [$];
  int         stop_err;
  bit         mon_busy;
  logic       mon_prev;
  logic [7:0] mon_b;

  initial begin
    mon_prev = 1'b1;
    mon_busy = 1'b0;
    stop_err = 0;
    forever begin
      @(negedge CLK);
      if (mon_prev && !UART_TX) begin
        mon_busy = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        if (!UART_TX) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge CLK);
            mon_b[i] = UART_TX;
          end
          repeat (CPB) @(negedge CLK);
          if (!UART_TX) stop_err++;
          rxq.push_back(mon_b);
        end
        mon_busy = 1'b0;
      end
      mon_prev = UART_TX;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge CLK);
    bus.word_data  = w;
    bus.word_valid = 1'b1;
    while (!bus.word_ready && t < 400) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.word_ready) check("push_ready", 32'(bus.word_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.word_valid = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge CLK);
    bus.finish = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.finish = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("rx_count", 32'(rxq.size()), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("done_set", 32'(done), 32'd1);
  endtask

  task automatic check_word_bytes(input string tag, input int base, input logic [31:0] w);
    logic [7:0] got;
    logic [7:0] exp;
    for (int j = 0; j < 4; j++) begin
      exp = 8'(w >> (24 - 8 * j));
      got = (base + j < rxq.size()) ? rxq[base + j] : 8'hxx;
      check(tag, 32'(got), 32'(exp));
    end
  endtask

  task automatic flush_monitor();
    int t;
    t = 0;
    while (mon_busy && t < 100) begin
      @(negedge CLK);
      t++;
    end
    rxq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(bus.word_ready), 32'd1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    flush_monitor();
  endtask

  int idx;
  int errs;
  int lows;
  logic exp_bit;

  initial begin
    n_vec = 0;
    n_miss = 0;
    RST_N = 1'b0;
    bus.word_data  = '0;
    bus.word_valid = 1'b0;
    bus.finish     = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    do_reset();

    // 1: single word, latency and byte order
    push_word(32'h1234_5678);
    check("t1_tx_n0", 32'(UART_TX), 32'd1);
    @(negedge CLK);
    check("t1_tx_n1", 32'(UART_TX), 32'd1);
    @(negedge CLK);
    check("t1_tx_n2_start", 32'(UART_TX), 32'd0);
    wait_bytes(4, 200);
    check_word_bytes("t1_byte", 0, 32'h1234_5678);
    repeat (3) @(negedge CLK);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_tx_idle", 32'(UART_TX), 32'd1);
    flush_monitor();

    // 2: six words with word_valid held high; FIFO fills
    idx = 0;
    @(negedge CLK);
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h0000_00A0;
    for (int t = 0; t < 2000 && idx < 6; t++) begin
      if (bus.word_ready) begin
        @(posedge CLK);
        idx++;
        @(negedge CLK);
        if (idx == 5) check("t2_ready_full", 32'(bus.word_ready), 32'd0);
        bus.word_data = 32'h0000_00A0 + 32'(idx);
      end else begin
        @(negedge CLK);
      end
    end
    bus.word_valid = 1'b0;
    check("t2_accepted", 32'(idx), 32'd6);
    wait_bytes(24, 1200);
    for (int w = 0; w < 6; w++) check_word_bytes("t2_byte", 4 * w, 32'h0000_00A0 + 32'(w));
    repeat (60) @(negedge CLK);
    check("t2_no_extra", 32'(rxq.size()), 32'd24);
    flush_monitor();

    // 6: all-zero word line shape, frames back to back
    push_word(32'h0000_0000);
    errs = 0;
    lows = 0;
    for (int j = 0; j < 162; j++) begin
      @(negedge CLK);
      if (j == 0 || j > 160) exp_bit = 1'b1;
      else exp_bit = (((j - 1) % 40) < 36) ? 1'b0 : 1'b1;
      if (UART_TX !== exp_bit) errs++;
      if (UART_TX === 1'b0) lows++;
    end
    check("t6_shape_errs", 32'(errs), 32'd0);
    check("t6_low_cycles", 32'(lows), 32'd144);
    flush_monitor();

    // 5: reset in the middle of bit 3 of byte 1 with two words queued
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    repeat (57) @(negedge CLK);
    check("t5_bit3_of_22", 32'(UART_TX), 32'd0);
    check("t5_busy_before", 32'(busy), 32'd1);
    RST_N = 1'b0;
    #1;
    check("t5_tx_in_reset", 32'(UART_TX), 32'd1);
    check("t5_busy_in_reset", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    flush_monitor();
    push_word(32'h5A5A_5A5A);
    wait_bytes(4, 200);
    check_word_bytes("t5_byte", 0, 32'h5A5A_5A5A);
    repeat (200) @(negedge CLK);
    check("t5_only_4", 32'(rxq.size()), 32'd4);
    flush_monitor();

    // 3: two words then finish; end marker follows
    push_word(32'h0000_0000);
    push_word(32'hFFFF_FF00);
    pulse_finish();
    check("t3_ready_after_fin", 32'(bus.word_ready), 32'd0);
    wait_bytes(11, 600);
    check("t3_done_early", 32'(done), 32'd0);
    wait_bytes(12, 100);
    check_word_bytes("t3_w0", 0, 32'h0000_0000);
    check_word_bytes("t3_w1", 4, 32'hFFFF_FF00);
    check_word_bytes("t3_mark", 8, 32'hFFFF_FFFF);
    wait_done(6);
    check("t3_busy_end", 32'(busy), 32'd0);

    // 4: finish when idle and empty sends only the marker
    do_reset();
    pulse_finish();
    wait_bytes(4, 200);
    check_word_bytes("t4_mark", 0, 32'hFFFF_FFFF);
    wait_done(6);
    check("t4_ready_done", 32'(bus.word_ready), 32'd0);
    @(negedge CLK);
    bus.finish     = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h1357_9BDF;
    @(negedge CLK);
    bus.finish     = 1'b0;
    bus.word_valid = 1'b0;
    repeat (60) @(negedge CLK);
    check("t4_no_more_bytes", 32'(rxq.size()), 32'd4);
    check("t4_busy_idle", 32'(busy), 32'd0);
    check("t4_done_sticky", 32'(done), 32'd1);
    check("t4_tx_idle", 32'(UART_TX), 32'd1);

    check("stop_bit_errors", 32'(stop_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
